// File: rtl/regfile_writeback_pkg.sv
// Shared constants and source encoding for the register file write-back path.
package regfile_writeback_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. The source that did not win last time has priority.
module rr_arbiter2
  import regfile_writeback_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       aluValid,
  input  logic       memValid,
  output logic       aluReady,
  output logic       memReady,
  output logic [1:0] grant
);

  src_e lastGrant;

  // Ready is a function of the other source only, so a producer can sample it before raising valid.
  always_comb begin
    aluReady = 1'b0;
    memReady = 1'b0;
    if (!rst) begin
      aluReady = !(memValid && (lastGrant == SRC_ALU));
      memReady = !(aluValid && (lastGrant == SRC_MEM));
    end
    grant          = 2'b00;
    grant[SRC_ALU] = aluValid && aluReady;
    grant[SRC_MEM] = memValid && memReady;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant <= SRC_MEM;
    end else if (grant[SRC_ALU]) begin
      lastGrant <= SRC_ALU;
    end else if (grant[SRC_MEM]) begin
      lastGrant <= SRC_MEM;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side driver for the register file: arbitrates ALU and load results into one
// registered write per cycle and tracks outstanding writes in a busy scoreboard.
module regfile_writeback
  import regfile_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              aluValid,
  output logic              aluReady,
  input  logic [ADDR_W-1:0] aluAdd,
  input  logic [DATA_W-1:0] aluData,
  input  logic              memValid,
  output logic              memReady,
  input  logic [ADDR_W-1:0] memAdd,
  input  logic [DATA_W-1:0] memData,
  input  logic              reserveEn,
  input  logic [ADDR_W-1:0] reserveAdd,
  output logic [DATA_W-1:0] writeData,
  output logic [ADDR_W-1:0] writeAdd,
  output logic              writeEn,
  output logic [NREG-1:0]   busy,
  output logic              errUnreserved
);

  logic [1:0]        grant;
  logic              transfer;
  logic              doWrite;
  logic [ADDR_W-1:0] selAdd;
  logic [DATA_W-1:0] selData;
  logic [NREG-1:0]   busyNext;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .aluValid (aluValid),
    .memValid (memValid),
    .aluReady (aluReady),
    .memReady (memReady),
    .grant    (grant)
  );

  always_comb begin
    transfer = |grant;
    selAdd   = grant[SRC_MEM] ? memAdd  : aluAdd;
    selData  = grant[SRC_MEM] ? memData : aluData;
    // Results for r0 are consumed but never reach the register file.
    doWrite  = transfer && (selAdd != ZERO_REG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writeEn   <= 1'b0;
      writeAdd  <= '0;
      writeData <= '0;
    end else begin
      writeEn <= doWrite;
      if (doWrite) begin
        writeAdd  <= selAdd;
        writeData <= selData;
      end
    end
  end

  // Reserve is applied after clear so a same-register reserve keeps the bit set.
  always_comb begin
    busyNext = busy;
    if (writeEn) begin
      busyNext[writeAdd] = 1'b0;
    end
    if (reserveEn && (reserveAdd != ZERO_REG)) begin
      busyNext[reserveAdd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= '0;
      errUnreserved <= 1'b0;
    end else begin
      busy <= busyNext;
      if (writeEn && !busy[writeAdd]) begin
        errUnreserved <= 1'b1;
      end
    end
  end

endmodule
